// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station with multi-port issue, squash and per-slot stall.
// Define RS_WAKEUP_BYPASS_EN to let a CDB broadcast make an entry issuable in the same cycle.
module rs_issue_queue #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 3,
  parameter int ISSUE_W    = 2,
  parameter int CDB_W      = 3,
  parameter int PR_W       = 6,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            squash,
  input  logic [DISPATCH_W-1:0]           in_valid,
  input  logic [DISPATCH_W*PR_W-1:0]      in_dest_pr,
  input  logic [DISPATCH_W*PR_W-1:0]      in_reg1_pr,
  input  logic [DISPATCH_W*PR_W-1:0]      in_reg2_pr,
  input  logic [DISPATCH_W-1:0]           in_reg1_ready,
  input  logic [DISPATCH_W-1:0]           in_reg2_ready,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] in_payload,
  output logic [DISPATCH_W-1:0]           struct_stall,
  input  logic [CDB_W-1:0]                cdb_valid,
  input  logic [CDB_W*PR_W-1:0]           cdb_tag,
  output logic [ISSUE_W-1:0]              issue_valid,
  input  logic [ISSUE_W-1:0]              issue_ready,
  output logic [ISSUE_W*PR_W-1:0]         issue_dest_pr,
  output logic [ISSUE_W*PR_W-1:0]         issue_reg1_pr,
  output logic [ISSUE_W*PR_W-1:0]         issue_reg2_pr,
  output logic [ISSUE_W*PAYLOAD_W-1:0]    issue_payload,
  output logic [DEPTH-1:0]                entry_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     r1_rdy_q;
  logic [DEPTH-1:0]     r2_rdy_q;
  logic [PR_W-1:0]      dest_q [DEPTH];
  logic [PR_W-1:0]      r1_q   [DEPTH];
  logic [PR_W-1:0]      r2_q   [DEPTH];
  logic [PAYLOAD_W-1:0] pay_q  [DEPTH];

  logic [CNT_W-1:0]      free_cnt;
  logic [DEPTH-1:0]      hit1, hit2, elig;
  logic [DEPTH-1:0]      picked, taken;
  logic [IDX_W-1:0]      sel [ISSUE_W];
  logic [DISPATCH_W-1:0] alloc_en;
  logic [IDX_W-1:0]      alloc_idx [DISPATCH_W];

  function automatic logic cdb_hit(
    input logic [PR_W-1:0]       tag,
    input logic [CDB_W-1:0]      v,
    input logic [CDB_W*PR_W-1:0] tags
  );
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (v[c] && tags[c*PR_W +: PR_W] == tag)
        cdb_hit = 1'b1;
  endfunction

  always_comb begin
    free_cnt = '0;
    for (int e = 0; e < DEPTH; e++)
      free_cnt = free_cnt + {{IDX_W{1'b0}}, ~valid_q[e]};
  end

  for (genvar s = 0; s < DISPATCH_W; s++) begin : g_stall
    assign struct_stall[s] = free_cnt < CNT_W'(DISPATCH_W - s);
  end

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      hit1[e] = cdb_hit(r1_q[e], cdb_valid, cdb_tag);
      hit2[e] = cdb_hit(r2_q[e], cdb_valid, cdb_tag);
    end
  end

`ifdef RS_WAKEUP_BYPASS_EN
  assign elig = valid_q & (r1_rdy_q | hit1) & (r2_rdy_q | hit2);
`else
  assign elig = valid_q & r1_rdy_q & r2_rdy_q;
`endif

  // Each port takes the highest-index eligible entry not claimed by a lower port.
  always_comb begin
    picked      = '0;
    issue_valid = '0;
    for (int p = 0; p < ISSUE_W; p++) begin
      sel[p] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (elig[e] && !picked[e]) begin
          sel[p]         = IDX_W'(e);
          issue_valid[p] = 1'b1;
        end
      end
      if (issue_valid[p])
        picked[sel[p]] = 1'b1;
    end
  end

  for (genvar p = 0; p < ISSUE_W; p++) begin : g_issue
    assign issue_dest_pr[p*PR_W +: PR_W]      = dest_q[sel[p]];
    assign issue_reg1_pr[p*PR_W +: PR_W]      = r1_q[sel[p]];
    assign issue_reg2_pr[p*PR_W +: PR_W]      = r2_q[sel[p]];
    assign issue_payload[p*PAYLOAD_W +: PAYLOAD_W] = pay_q[sel[p]];
  end

  // Oldest slot first, each grabbing the highest free entry left.
  always_comb begin
    taken    = '0;
    alloc_en = '0;
    for (int s = 0; s < DISPATCH_W; s++)
      alloc_idx[s] = '0;
    for (int s = DISPATCH_W - 1; s >= 0; s--) begin
      if (in_valid[s] && !struct_stall[s]) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (!valid_q[e] && !taken[e]) begin
            alloc_idx[s] = IDX_W'(e);
            alloc_en[s]  = 1'b1;
          end
        end
        if (alloc_en[s])
          taken[alloc_idx[s]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q  <= '0;
      r1_rdy_q <= '0;
      r2_rdy_q <= '0;
    end else if (squash) begin
      valid_q <= '0;
    end else begin
      r1_rdy_q <= r1_rdy_q | (hit1 & valid_q);
      r2_rdy_q <= r2_rdy_q | (hit2 & valid_q);
      for (int p = 0; p < ISSUE_W; p++)
        if (issue_valid[p] && issue_ready[p])
          valid_q[sel[p]] <= 1'b0;
      for (int s = 0; s < DISPATCH_W; s++) begin
        if (alloc_en[s]) begin
          valid_q[alloc_idx[s]]  <= 1'b1;
          r1_rdy_q[alloc_idx[s]] <= in_reg1_ready[s] |
            cdb_hit(in_reg1_pr[s*PR_W +: PR_W], cdb_valid, cdb_tag);
          r2_rdy_q[alloc_idx[s]] <= in_reg2_ready[s] |
            cdb_hit(in_reg2_pr[s*PR_W +: PR_W], cdb_valid, cdb_tag);
          dest_q[alloc_idx[s]]   <= in_dest_pr[s*PR_W +: PR_W];
          r1_q[alloc_idx[s]]     <= in_reg1_pr[s*PR_W +: PR_W];
          r2_q[alloc_idx[s]]     <= in_reg2_pr[s*PR_W +: PR_W];
          pay_q[alloc_idx[s]]    <= in_payload[s*PAYLOAD_W +: PAYLOAD_W];
        end
      end
    end
  end

  assign entry_valid = valid_q;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed literals.
module tb_rs_issue_queue;
  localparam int DEPTH = 16;
  localparam int DW    = 3;
  localparam int IW    = 2;
  localparam int CW    = 3;
  localparam int PR_W  = 6;
  localparam int PW    = 64;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock, reset_n, squash;
  logic [DW-1:0]      in_valid, in_reg1_ready, in_reg2_ready, struct_stall;
  logic [DW*PR_W-1:0] in_dest_pr, in_reg1_pr, in_reg2_pr;
  logic [DW*PW-1:0]   in_payload;
  logic [CW-1:0]      cdb_valid;
  logic [CW*PR_W-1:0] cdb_tag;
  logic [IW-1:0]      issue_valid, issue_ready;
  logic [IW*PR_W-1:0] issue_dest_pr, issue_reg1_pr, issue_reg2_pr;
  logic [IW*PW-1:0]   issue_payload;
  logic [DEPTH-1:0]   entry_valid;

  logic [PR_W-1:0] d_dest [DW];
  logic [PR_W-1:0] d_r1   [DW];
  logic [PR_W-1:0] d_r2   [DW];
  logic [PW-1:0]   d_pay  [DW];
  logic [PR_W-1:0] c_tag  [CW];

  for (genvar s = 0; s < DW; s++) begin : g_pk
    assign in_dest_pr[s*PR_W +: PR_W] = d_dest[s];
    assign in_reg1_pr[s*PR_W +: PR_W] = d_r1[s];
    assign in_reg2_pr[s*PR_W +: PR_W] = d_r2[s];
    assign in_payload[s*PW +: PW]     = d_pay[s];
  end
  for (genvar c = 0; c < CW; c++) begin : g_cdb
    assign cdb_tag[c*PR_W +: PR_W] = c_tag[c];
  end

  rs_issue_queue dut (
    .clock(clock), .reset_n(reset_n), .squash(squash),
    .in_valid(in_valid), .in_dest_pr(in_dest_pr),
    .in_reg1_pr(in_reg1_pr), .in_reg2_pr(in_reg2_pr),
    .in_reg1_ready(in_reg1_ready), .in_reg2_ready(in_reg2_ready),
    .in_payload(in_payload), .struct_stall(struct_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest_pr(issue_dest_pr), .issue_reg1_pr(issue_reg1_pr),
    .issue_reg2_pr(issue_reg2_pr), .issue_payload(issue_payload),
    .entry_valid(entry_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one record per entry index.
  bit              m_v  [DEPTH];
  bit              m_k1 [DEPTH];
  bit              m_k2 [DEPTH];
  logic [PR_W-1:0] m_d  [DEPTH];
  logic [PR_W-1:0] m_s1 [DEPTH];
  logic [PR_W-1:0] m_s2 [DEPTH];
  logic [PW-1:0]   m_p  [DEPTH];
  int eq[$];
  int fl[$];

  function automatic bit m_hit(input logic [PR_W-1:0] t);
    for (int c = 0; c < CW; c++)
      if (cdb_valid[c] && c_tag[c] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ok(input int e);
    bit a, b;
    a = m_k1[e] || (BYP && m_hit(m_s1[e]));
    b = m_k2[e] || (BYP && m_hit(m_s2[e]));
    return m_v[e] && a && b;
  endfunction

  function automatic void m_build();
    eq.delete();
    for (int e = DEPTH - 1; e >= 0; e--)
      if (m_ok(e)) eq.push_back(e);
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int e = 0; e < DEPTH; e++) if (!m_v[e]) n++;
    return n;
  endfunction

  always @(posedge clock) begin
    int fc, e;
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_v[i] = 0; m_k1[i] = 0; m_k2[i] = 0;
      end
    end else if (squash) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    end else begin
      m_build();
      fl.delete();
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fl.push_back(i);
      fc = fl.size();
      for (int i = 0; i < DEPTH; i++) begin
        if (m_v[i] && m_hit(m_s1[i])) m_k1[i] = 1;
        if (m_v[i] && m_hit(m_s2[i])) m_k2[i] = 1;
      end
      for (int p = 0; p < IW; p++)
        if (p < eq.size() && issue_ready[p]) m_v[eq[p]] = 0;
      for (int s = DW - 1; s >= 0; s--) begin
        if (in_valid[s] && fc >= DW - s) begin
          e = fl.pop_front();
          m_v[e]  = 1;
          m_d[e]  = d_dest[s];
          m_s1[e] = d_r1[s];
          m_s2[e] = d_r2[s];
          m_p[e]  = d_pay[s];
          m_k1[e] = in_reg1_ready[s] || m_hit(d_r1[s]);
          m_k2[e] = in_reg2_ready[s] || m_hit(d_r2[s]);
        end
      end
    end
  end

  always @(negedge clock) begin
    logic [DW-1:0]    es;
    logic [DEPTH-1:0] ev;
    logic [IW-1:0]    ei;
    int fc;
    if (chk_en) begin
      m_build();
      fc = m_free();
      for (int s = 0; s < DW; s++) es[s] = fc < DW - s;
      for (int e = 0; e < DEPTH; e++) ev[e] = m_v[e];
      for (int p = 0; p < IW; p++) ei[p] = p < eq.size();
      chk("struct_stall", struct_stall, es);
      chk("entry_valid", entry_valid, ev);
      chk("issue_valid", issue_valid, ei);
      for (int p = 0; p < IW; p++) begin
        if (ei[p]) begin
          chk("issue_dest", issue_dest_pr[p*PR_W +: PR_W], m_d[eq[p]]);
          chk("issue_reg1", issue_reg1_pr[p*PR_W +: PR_W], m_s1[eq[p]]);
          chk("issue_reg2", issue_reg2_pr[p*PR_W +: PR_W], m_s2[eq[p]]);
          chk("issue_payload", issue_payload[p*PW +: PW], m_p[eq[p]]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    in_valid = '0;
    in_reg1_ready = '0;
    in_reg2_ready = '0;
    cdb_valid = '0;
    squash = 1'b0;
  endtask

  task automatic disp(input int s, input int dst, input int r1, input bit k1,
                      input int r2, input bit k2, input logic [PW-1:0] pay);
    in_valid[s]      = 1'b1;
    d_dest[s]        = PR_W'(dst);
    d_r1[s]          = PR_W'(r1);
    d_r2[s]          = PR_W'(r2);
    in_reg1_ready[s] = k1;
    in_reg2_ready[s] = k2;
    d_pay[s]         = pay;
  endtask

  initial begin
    reset_n = 1'b0; squash = 1'b0; issue_ready = '0;
    in_valid = '0; in_reg1_ready = '0; in_reg2_ready = '0; cdb_valid = '0;
    for (int s = 0; s < DW; s++) begin
      d_dest[s] = '0; d_r1[s] = '0; d_r2[s] = '0; d_pay[s] = '0;
    end
    for (int c = 0; c < CW; c++) c_tag[c] = '0;
    step();
    step();
    reset_n = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_ev", entry_valid, 0);
    chk("rst_iv", issue_valid, 0);
    chk("rst_stall", struct_stall, 0);

    // fill 15 entries, then only slot 2 fits
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s < DW; s++)
        disp(s, k*3 + s, 60, 1, 61, 1, {32'(k), 32'(s)});
      step();
    end
    #1;
    chk("fill_ev", entry_valid, 16'hFFFE);
    chk("fill_stall", struct_stall, 3'b011);
    for (int s = 0; s < DW; s++) disp(s, 20 + s, 60, 1, 61, 1, 64'hBEEF);
    step();
    #1;
    chk("full_ev", entry_valid, 16'hFFFF);
    chk("full_stall", struct_stall, 3'b111);
    chk("full_p0_dest", issue_dest_pr[5:0], 2);
    chk("full_p1_dest", issue_dest_pr[11:6], 1);
    chk("full_p0_pay", issue_payload[63:0], 64'h2);
    issue_ready = 2'b11;
    #1;
    chk("full_issue_stall", struct_stall, 3'b111);
    step();
    #1;
    chk("freed_ev", entry_valid, 16'h3FFF);
    chk("freed_stall", struct_stall, 3'b001);

    // reset while both ports are handshaking
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    issue_ready = '0;
    #1;
    chk("mid_rst_ev", entry_valid, 0);
    chk("mid_rst_iv", issue_valid, 0);
    chk("mid_rst_stall", struct_stall, 0);

    // wakeup latency
    disp(2, 50, 5, 0, 6, 1, 64'h55);
    step();
    cdb_valid = 3'b001;
    c_tag[0] = 6'd5;
    #1;
    chk("wake_t_iv", issue_valid, BYP ? 2'b01 : 2'b00);
    step();
    #1;
    chk("wake_t1_iv", issue_valid, 2'b01);
    chk("wake_t1_dest", issue_dest_pr[5:0], 50);
    issue_ready = 2'b01;
    step();
    issue_ready = '0;
    #1;
    chk("wake_done_ev", entry_valid, 0);

    // dispatch-time capture
    disp(2, 51, 1, 1, 9, 0, 64'h99);
    cdb_valid = 3'b010;
    c_tag[1] = 6'd9;
    step();
    #1;
    chk("cap_iv", issue_valid, 2'b01);
    chk("cap_reg2", issue_reg2_pr[5:0], 9);
    issue_ready = 2'b01;
    step();
    issue_ready = '0;
    #1;
    chk("cap_done_ev", entry_valid, 0);

    // dual issue with port 1 backpressured
    disp(2, 40, 60, 1, 61, 1, 64'h40);
    disp(1, 41, 60, 1, 61, 1, 64'h41);
    disp(0, 42, 60, 1, 61, 1, 64'h42);
    step();
    disp(2, 43, 60, 1, 61, 1, 64'h43);
    step();
    issue_ready = 2'b01;
    #1;
    chk("dual_iv", issue_valid, 2'b11);
    chk("dual_p0", issue_dest_pr[5:0], 40);
    chk("dual_p1", issue_dest_pr[11:6], 41);
    step();
    issue_ready = '0;
    #1;
    chk("dual2_p0", issue_dest_pr[5:0], 41);
    chk("dual2_p1", issue_dest_pr[11:6], 42);
    chk("dual2_ev", entry_valid, 16'h7000);

    // squash with 10 valid entries and a live dispatch
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < DW; s++) disp(s, 30 + k*3 + s, 60, 1, 61, 1, 64'(k));
      step();
    end
    disp(2, 39, 60, 1, 61, 1, 64'h39);
    step();
    #1;
    chk("pre_squash_ev", entry_valid, 16'hFFC0);
    squash = 1'b1;
    issue_ready = 2'b11;
    for (int s = 0; s < DW; s++) disp(s, 10 + s, 60, 1, 61, 1, 64'h7);
    step();
    issue_ready = '0;
    #1;
    chk("squash_ev", entry_valid, 0);
    chk("squash_iv", issue_valid, 0);
    chk("squash_stall", struct_stall, 0);

    // mixed traffic, model-checked every cycle
    for (int n = 0; n < 60; n++) begin
      for (int s = 0; s < DW; s++) begin
        if ($urandom_range(0, 1) == 1)
          disp(s, $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 3) == 0,
               $urandom_range(0, 7), $urandom_range(0, 3) == 0, {$urandom, $urandom});
      end
      for (int c = 0; c < CW; c++) begin
        cdb_valid[c] = $urandom_range(0, 2) == 0;
        c_tag[c] = PR_W'($urandom_range(0, 7));
      end
      issue_ready = IW'($urandom_range(0, 3));
      squash = $urandom_range(0, 19) == 0;
      step();
    end
    issue_ready = '0;
    step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs_issue_queue.md
# rs_issue_queue

Parametrised reservation station for the out-of-order core. It sits between dispatch and the functional units. It accepts up to `DISPATCH_W` renamed instructions per cycle. It captures operand readiness from up to `CDB_W` CDB tag broadcasts, and issues up to `ISSUE_W` ready entries per cycle under a valid/ready handshake with the FUs. Compared with the fixed 16-entry, 3-wide RS, it adds multi-port issue, a flush path, and per-slot backpressure.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two.
- `DISPATCH_W`, 3: dispatch slots per cycle. Slot `DISPATCH_W-1` is the oldest.
- `ISSUE_W`, 2: issue ports.
- `CDB_W`, 3: CDB broadcast ports.
- `PR_W`, 6: physical register tag width.
- `PAYLOAD_W`, 64: opaque payload carried through unchanged, e.g. {NPC, inst}.

Ports:
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `squash`  in  1  flush all entries (branch mispredict).
- `in_valid`  in  DISPATCH_W  dispatch slot valid.
- `in_dest_pr`  in  DISPATCH_W*PR_W  destination tag per slot.
- `in_reg1_pr`, `in_reg2_pr`  in  DISPATCH_W*PR_W  source tags per slot.
- `in_reg1_ready`, `in_reg2_ready`  in  DISPATCH_W  source already available.
- `in_payload`  in  DISPATCH_W*PAYLOAD_W  payload per slot.
- `struct_stall`  out  DISPATCH_W  per slot: 1 means the slot is not accepted this cycle.
- `cdb_valid`  in  CDB_W  broadcast valid.
- `cdb_tag`  in  CDB_W*PR_W  broadcast tags.
- `issue_valid`  out  ISSUE_W  issue port holds an entry.
- `issue_ready`  in  ISSUE_W  FU accepts.
- `issue_dest_pr`, `issue_reg1_pr`, `issue_reg2_pr`  out  ISSUE_W*PR_W  tags of the issued entry.
- `issue_payload`  out  ISSUE_W*PAYLOAD_W  payload of the issued entry.
- `entry_valid`  out  DEPTH  occupancy vector, for debug and the bench.

## Operation
- **Free count.** `free_cnt` is the number of invalid entries at the start of the cycle. Entries freed this cycle are not reusable until the next cycle.
- **Structural stall.** `struct_stall[s] = (free_cnt < DISPATCH_W - s)`. The rule is combinational from state only and independent of `in_valid`.
- **Allocation.** Valid, non-stalled slots are allocated in order, oldest slot first. Each takes the highest-index free entry remaining, so entries fill from `DEPTH-1` toward 0. Invalid slots consume no entry.
- **Dispatch-time capture.** If an incoming source tag matches any valid CDB tag in the same cycle, that operand is written ready.
- **Wakeup.** Each cycle, every valid entry sets `regX_ready` for any source tag matching a valid `cdb_tag`. Ready bits never clear while the entry is valid.
- **Issue eligibility.** An entry is eligible when it is valid and both operands are ready.
- **Issue selection.** Port 0 takes the highest-index eligible entry, port 1 the next, and so on. Unused ports drive `issue_valid=0`.
- **Issue handshake.**
  - An entry is freed at the clock edge where its port has `issue_valid && issue_ready`.
  - If `issue_ready=0`, the entry stays and selection is recomputed next cycle; the same entry normally reappears.
- **Squash.** All entries are invalidated at the edge. Dispatch in that cycle is dropped, and issue handshakes that cycle are ignored. The FU side must discard squashed work.
- **Reset (`reset_n=0` at the edge).**
  - All entries become invalid and all ready bits clear.
  - Afterwards `issue_valid=0`, `struct_stall=0`, `entry_valid=0`, `free_cnt=DEPTH`.
- **Priority.** Reset beats squash, which beats dispatch, issue and wakeup.

## Timing
- **Dispatch.** Dispatch at edge t makes the entry visible in `entry_valid` after t. The earliest issue is the cycle after t.
- **CDB broadcast.** With bypass (see Configuration), a broadcast in cycle t can make an existing entry eligible in cycle t. Without bypass, the entry becomes eligible in cycle t+1.
- **Combinational paths.** Issue outputs are combinational from entry state, plus CDB when bypass is on. `struct_stall` is combinational from state only.
- **Full case.** With `free_cnt=0`, all `struct_stall` bits are 1, even in a cycle where entries issue.
- **Mid-operation reset.** Any in-flight handshake is abandoned with no side effects.

## Configuration
- **`RS_WAKEUP_BYPASS_EN` defined.**
  - Eligibility also counts operands whose tag matches a valid CDB tag this cycle.
  - Such entries may issue in the broadcast cycle; zero-cycle wakeup-to-issue.
- **`RS_WAKEUP_BYPASS_EN` undefined.**
  - Eligibility uses stored ready bits only; one-cycle wakeup-to-issue.
- **Always on in both builds.** Dispatch-time capture, so no wakeup is ever missed.

## Test plan
- **Reset then fill.** Reset, then dispatch 3 all-ready instructions per cycle with `issue_ready=0`.
  - After cycle 5: entries 15..1 are valid and `free_cnt=1`.
  - `struct_stall=3'b011`; only slot 2 is accepted next, into entry 0.
  - Then `struct_stall=3'b111`.
- **Wakeup.** Dispatch one entry with `reg1_pr=5` not ready. Broadcast `cdb_tag=5` in cycle t.
  - With the macro: `issue_valid[0]=1` in cycle t.
  - Without the macro: `issue_valid[0]=1` in cycle t+1.
- **Dispatch-time capture.** Dispatch `reg2_pr=9` not ready in the same cycle CDB broadcasts tag 9.
  - The entry issues the next cycle in both builds.
- **Dual issue with backpressure.** Load 4 ready entries (15..12) and set `issue_ready=2'b01`.
  - Port 0 issues 15 and port 1 shows 14 but keeps it.
  - Next cycle: port 0 shows 14 and port 1 shows 13.
- **Squash.** Squash with 10 valid entries and a simultaneous valid dispatch.
  - Next cycle: `entry_valid=0`, `issue_valid=0`, `struct_stall=0`.
- **Reset mid-operation.** Assert `reset_n=0` while entries are issuing.
  - Next cycle: all outputs are at their reset values and no entries remain.
